alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester controller that shares the single core ALU between an integer-issue port (requester 0) and an auxiliary port (requester 1, e.g. address/branch unit). It accepts one operation at a time over valid/ready, drives the ALU operation and operands from registers, captures the result, and returns it to the owning requester over a second valid/ready channel. Arbitration is round-robin. At most one operation is in flight.

## Interface
- Parameters: none. The opcode is 4 bits and the data path is 32 bits, both fixed.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `reqN_valid` in 1 (N=0,1): request present.
- `reqN_ready` out 1: request accepted this cycle.
- `reqN_op` in 4: ALU opcode.
- `reqN_a` in 32: operand 1.
- `reqN_b` in 32: operand 2.
- `respN_valid` out 1: result for requester N is held.
- `respN_ready` in 1: requester N takes the result.
- `respN_data` out 32: result.
- `respN_err` out 1: opcode was unsupported.
- `alu_op` out 4: registered opcode to the core ALU.
- `alu_op1` out 32: registered operand 1 to the core ALU.
- `alu_op2` out 32: registered operand 2 to the core ALU.
- `alu_result` in 32: combinational ALU result.
- `busy` out 1: high in EXEC or RESP.

## Operation
- ALU opcodes: 0000 sll, 0001 srl, 0010 sra, 0011 add, 0100 sub, 0101 and, 0110 or, 0111 xor, 1000 slt (signed), 1001 eq, 1010 ne. Opcodes 1011–1111 are unsupported.
- States:
  - IDLE → EXEC when a request is accepted.
  - EXEC → RESP unconditionally.
  - RESP → IDLE on a response handshake with no new accept.
  - RESP → EXEC on a response handshake with a same-cycle accept.
- Grant:
  - `prio` register, reset 0, names the favoured requester.
  - Only one requester valid: that requester is granted.
  - Both valid: requester `prio` is granted.
  - After each accept, `prio` becomes the non-granted index.
- Accept:
  - `reqN_ready` = grantN && (state==IDLE || response handshake this cycle) && !rst.
  - `reqN_ready` is combinational on `reqN_valid`, `respM_ready` and state. This is permitted.
  - On accept, latch the opcode into `alu_op`, the operands into `alu_op1`/`alu_op2`, the owner index, and `bad` = (op > 1010).
- EXEC: capture `bad ? 0 : alu_result` into the response register. Set `respN_err` = `bad` for the owner.
- RESP:
  - `resp[owner]_valid` = 1. The other requester's response valid = 0.
  - Data and err are held stable until `resp[owner]_ready` = 1.
- Requester rules:
  - Once `reqN_valid` is high, the requester holds it and its payload until `reqN_ready`.
  - The controller never drops an unaccepted request.
- `alu_op`/`alu_op1`/`alu_op2` keep their last values outside EXEC. The ALU is never left with an undriven opcode.
- Reset behaviour:
  - Any cycle with `rst`=1: next state IDLE, `prio` 0, in-flight op discarded.
  - No response is produced for a discarded op.
  - No ready is asserted in the reset cycle.

## Timing
- Reset values:
  - `reqN_ready` 0 (combinational, forced low during `rst`).
  - `respN_valid` 0, `respN_data` 0, `respN_err` 0.
  - `alu_op` 0000, `alu_op1` 0, `alu_op2` 0.
  - `busy` 0.
- Latency: accept at edge T → ALU driven during cycle T+1 → `respN_valid` high from cycle T+2.
- Throughput:
  - With back-to-back accepts, one op per 2 cycles.
  - Isolated ops take 3 cycles, including the IDLE cycle.
- Back-pressure: RESP persists indefinitely while `resp[owner]_ready`=0. During that time no request is accepted and `busy`=1.
- Simultaneous response handshake and new request (either requester): the new request is accepted in the same cycle and goes to EXEC next. `respN_valid` drops for one cycle only if the same requester is re-granted.
- `respM_ready` asserted while `respM_valid`=0 is ignored.

## Test plan
- Single add, requester 0: after reset, req0 op=0011, a=5, b=7 in cycle 1 → `req0_ready`=1 in cycle 1, `alu_op`=0011 in cycle 2, `resp0_valid`=1 with data 12 and err 0 from cycle 3, `busy` 1 in cycles 2–3.
- Contention: both valid in the same cycle after reset, req0 sub 10−3, req1 and 0xF0&0x3C → req0 granted first (resp0 = 7). With `resp0_ready`=1, req1 is accepted in the resp0 handshake cycle, and resp1 = 0x30 arrives 2 cycles later.
- Fairness: both requesters continuously valid for 6 ops with responses always ready → grant order 0,1,0,1,0,1, one op per 2 cycles.
- Back-pressure: `resp1_ready`=0 for 5 cycles on slt(−1, 1) → `resp1_data`=1 held stable, `req0_ready` stays 0 throughout, req0 accepted on the handshake cycle.
- Unsupported op: req0 op=1100, a=3, b=4 → `resp0_data`=0, `resp0_err`=1. The next valid op returns err=0.
- Reset mid-op: `rst` asserted in EXEC of add 1+1 → no response ever appears for it; `busy`=0 and all outputs at reset values the cycle after. A pending req1 is granted only after `rst` deasserts.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one core ALU between two requesters.
// Requester 0 is the integer-issue port and requester 1 is the auxiliary port.
// Arbitration is round-robin, and at most one operation is in flight.
// Each operation goes IDLE/RESP (accept) -> EXEC (ALU driven) -> RESP (result held).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b           request channel, N=0,1 (ready is combinational)
//   respN_valid/ready/data/err        response channel, N=0,1
//   alu_op, alu_op1, alu_op2          registered opcode/operands to the core ALU
//   alu_result                        combinational result from the core ALU
//   busy                              high while in EXEC or RESP
module alu_share_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_data,
   output logic        resp0_err,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_data,
   output logic        resp1_err,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   input  logic [31:0] alu_result,
   output logic        busy
);

   localparam int unsigned OP_W   = 4;
   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Highest supported opcode (ne); anything above it is flagged as an error.
   localparam logic [OP_W-1:0] OP_MAX = OP_W'(4'b1010);

   logic [1:0]        state;
   logic [1:0]        next_state;
   logic              prio;
   logic              owner;
   logic              bad;
   logic              grant0;
   logic              grant1;
   logic              resp_hs;
   logic              accept;
   logic              sel;
   logic [OP_W-1:0]   sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;

   // Round-robin grant, accept window and request mux
   always_comb begin
      grant0  = req0_valid && (!req1_valid || !prio);
      grant1  = req1_valid && (!req0_valid ||  prio);
      // Only the owner's response valid is high in RESP, so its ready alone completes the handshake.
      resp_hs = (state == S_RESP) && (owner ? resp1_ready : resp0_ready);
      req0_ready = grant0 && ((state == S_IDLE) || resp_hs) && !rst;
      req1_ready = grant1 && ((state == S_IDLE) || resp_hs) && !rst;
      accept  = req0_ready || req1_ready;
      sel     = req1_ready;
      sel_op  = sel ? req1_op : req0_op;
      sel_a   = sel ? req1_a  : req0_a;
      sel_b   = sel ? req1_b  : req0_b;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (accept) next_state = S_EXEC;
         S_EXEC:  next_state = S_RESP;
         S_RESP:  if (resp_hs) next_state = accept ? S_EXEC : S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // State, operand latch, result capture and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         prio        <= 1'b0;
         owner       <= 1'b0;
         bad         <= 1'b0;
         alu_op      <= '0;
         alu_op1     <= '0;
         alu_op2     <= '0;
         resp0_valid <= 1'b0;
         resp0_data  <= '0;
         resp0_err   <= 1'b0;
         resp1_valid <= 1'b0;
         resp1_data  <= '0;
         resp1_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != S_IDLE);
         if (accept) begin
            prio    <= !sel;
            owner   <= sel;
            alu_op  <= sel_op;
            alu_op1 <= sel_a;
            alu_op2 <= sel_b;
            bad     <= (sel_op > OP_MAX);
         end
         if (state == S_EXEC) begin
            if (owner) begin
               resp1_data <= bad ? '0 : alu_result;
               resp1_err  <= bad;
            end else begin
               resp0_data <= bad ? '0 : alu_result;
               resp0_err  <= bad;
            end
         end
         // Owner cannot change except on an accept, which always leads to EXEC.
         resp0_valid <= (next_state == S_RESP) && !owner;
         resp1_valid <= (next_state == S_RESP) &&  owner;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed self-checking bench for alu_share_ctrl.
// A behavioural core ALU drives alu_result from the DUT's registered opcode and operands.
module tb_alu_share_ctrl;

   logic        clk;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [3:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [3:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic        resp0_valid, resp0_ready, resp0_err;
   logic [31:0] resp0_data;
   logic        resp1_valid, resp1_ready, resp1_err;
   logic [31:0] resp1_data;
   logic [3:0]  alu_op;
   logic [31:0] alu_op1, alu_op2, alu_result;
   logic        busy;

   int n_chk;
   int n_err;

   alu_share_ctrl dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp0_data(resp0_data), .resp0_err(resp0_err),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_data(resp1_data), .resp1_err(resp1_err),
      .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_result(alu_result), .busy(busy)
   );

   // Core ALU; unsupported opcodes return junk so that result masking is visible.
   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      case (op)
         4'd0:    return a << b[4:0];
         4'd1:    return a >> b[4:0];
         4'd2:    return 32'($signed(a) >>> b[4:0]);
         4'd3:    return a + b;
         4'd4:    return a - b;
         4'd5:    return a & b;
         4'd6:    return a | b;
         4'd7:    return a ^ b;
         4'd8:    return {31'd0, ($signed(a) < $signed(b))};
         4'd9:    return {31'd0, (a == b)};
         4'd10:   return {31'd0, (a != b)};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign alu_result = alu_f(alu_op, alu_op1, alu_op2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let the combinational ready settle before sampling.
   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   int grant_idx [6];
   int grant_cyc [6];
   int n_grant;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;

      // Reset state, with a pending request that must not be readied
      tick();
      req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd5; req0_b = 32'd7;
      settle();
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      tick();
      settle();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
      chk("rst_resp1_valid", 32'(resp1_valid), 32'd0);
      chk("rst_alu_op", 32'(alu_op), 32'd0);
      chk("rst_alu_op1", alu_op1, 32'd0);
      chk("rst_resp0_data", resp0_data, 32'd0);
      req0_valid = 1'b0;

      // Single add on requester 0
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd5; req0_b = 32'd7;
      settle();
      chk("add_req0_ready", 32'(req0_ready), 32'd1);
      chk("add_busy_c1", 32'(busy), 32'd0);
      tick();
      req0_valid = 1'b0;
      settle();
      chk("add_alu_op", 32'(alu_op), 32'd3);
      chk("add_alu_op1", alu_op1, 32'd5);
      chk("add_alu_op2", alu_op2, 32'd7);
      chk("add_busy_c2", 32'(busy), 32'd1);
      chk("add_resp0_valid_c2", 32'(resp0_valid), 32'd0);
      tick();
      resp0_ready = 1'b1;
      settle();
      chk("add_resp0_valid", 32'(resp0_valid), 32'd1);
      chk("add_resp0_data", resp0_data, 32'd12);
      chk("add_resp0_err", 32'(resp0_err), 32'd0);
      chk("add_busy_c3", 32'(busy), 32'd1);
      tick();
      resp0_ready = 1'b0;
      settle();
      chk("add_resp0_valid_c4", 32'(resp0_valid), 32'd0);
      chk("add_busy_c4", 32'(busy), 32'd0);

      // Contention: after reset requester 0 is favoured
      do_reset();
      req0_valid = 1'b1; req0_op = 4'd4; req0_a = 32'd10; req0_b = 32'd3;
      req1_valid = 1'b1; req1_op = 4'd5; req1_a = 32'hF0; req1_b = 32'h3C;
      settle();
      chk("ct_req0_ready", 32'(req0_ready), 32'd1);
      chk("ct_req1_ready", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      settle();
      chk("ct_req1_ready_exec", 32'(req1_ready), 32'd0);
      tick();
      resp0_ready = 1'b1;
      settle();
      chk("ct_resp0_valid", 32'(resp0_valid), 32'd1);
      chk("ct_resp0_data", resp0_data, 32'd7);
      chk("ct_req1_ready_hs", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0; resp0_ready = 1'b0;
      settle();
      chk("ct_resp0_valid_drop", 32'(resp0_valid), 32'd0);
      chk("ct_alu_op", 32'(alu_op), 32'd5);
      chk("ct_resp1_valid_early", 32'(resp1_valid), 32'd0);
      tick();
      resp1_ready = 1'b1;
      settle();
      chk("ct_resp1_valid", 32'(resp1_valid), 32'd1);
      chk("ct_resp1_data", resp1_data, 32'h30);
      tick();
      resp1_ready = 1'b0;

      // Fairness: both continuously valid, responses always ready
      do_reset();
      req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd1; req0_b = 32'd2;
      req1_valid = 1'b1; req1_op = 4'd6; req1_a = 32'd1; req1_b = 32'd2;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      n_grant = 0;
      for (int c = 0; c < 20 && n_grant < 6; c++) begin
         settle();
         if (req0_ready || req1_ready) begin
            grant_idx[n_grant] = req1_ready ? 1 : 0;
            grant_cyc[n_grant] = c;
            n_grant++;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("fair_count", 32'(n_grant), 32'd6);
      for (int i = 0; i < n_grant; i++) begin
         chk($sformatf("fair_grant%0d", i), 32'(grant_idx[i]), 32'(i % 2));
         if (i > 0)
            chk($sformatf("fair_gap%0d", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd2);
      end
      tick();
      tick();
      resp0_ready = 1'b0; resp1_ready = 1'b0;

      // Back-pressure on requester 1 slt(-1, 1) while requester 0 waits
      do_reset();
      req1_valid = 1'b1; req1_op = 4'd8; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
      settle();
      chk("bp_req1_ready", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd2; req0_b = 32'd3;
      settle();
      chk("bp_req0_ready_exec", 32'(req0_ready), 32'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         settle();
         chk($sformatf("bp_resp1_valid%0d", c), 32'(resp1_valid), 32'd1);
         chk($sformatf("bp_resp1_data%0d", c), resp1_data, 32'd1);
         chk($sformatf("bp_req0_ready%0d", c), 32'(req0_ready), 32'd0);
         chk($sformatf("bp_busy%0d", c), 32'(busy), 32'd1);
      end
      tick();
      resp1_ready = 1'b1;
      settle();
      chk("bp_req0_ready_hs", 32'(req0_ready), 32'd1);
      tick();
      resp1_ready = 1'b0; req0_valid = 1'b0;
      settle();
      chk("bp_resp1_valid_drop", 32'(resp1_valid), 32'd0);
      chk("bp_alu_op", 32'(alu_op), 32'd3);
      tick();
      resp0_ready = 1'b1;
      settle();
      chk("bp_resp0_data", resp0_data, 32'd5);
      tick();
      resp0_ready = 1'b0;

      // Unsupported opcode, then a back-to-back valid op on the same requester
      req0_valid = 1'b1; req0_op = 4'b1100; req0_a = 32'd3; req0_b = 32'd4;
      settle();
      chk("bad_req0_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tick();
      settle();
      chk("bad_resp0_valid", 32'(resp0_valid), 32'd1);
      chk("bad_resp0_data", resp0_data, 32'd0);
      chk("bad_resp0_err", 32'(resp0_err), 32'd1);
      resp0_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 4'd7; req0_a = 32'hFF; req0_b = 32'h0F;
      settle();
      chk("b2b_req0_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0; resp0_ready = 1'b0;
      settle();
      chk("b2b_resp0_valid_gap", 32'(resp0_valid), 32'd0);
      tick();
      resp0_ready = 1'b1;
      settle();
      chk("b2b_resp0_data", resp0_data, 32'hF0);
      chk("b2b_resp0_err", 32'(resp0_err), 32'd0);
      tick();
      resp0_ready = 1'b0;

      // Reset in EXEC discards the op; pending requester 1 waits for reset release
      req0_valid = 1'b1; req0_op = 4'd3; req0_a = 32'd1; req0_b = 32'd1;
      settle();
      chk("rm_req0_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      rst = 1'b1;
      req1_valid = 1'b1; req1_op = 4'd3; req1_a = 32'd1; req1_b = 32'd2;
      settle();
      chk("rm_req1_ready_rst", 32'(req1_ready), 32'd0);
      tick();
      rst = 1'b0;
      settle();
      chk("rm_busy", 32'(busy), 32'd0);
      chk("rm_resp0_valid", 32'(resp0_valid), 32'd0);
      chk("rm_alu_op", 32'(alu_op), 32'd0);
      chk("rm_alu_op1", alu_op1, 32'd0);
      chk("rm_resp0_data", resp0_data, 32'd0);
      chk("rm_req1_ready", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      settle();
      chk("rm_resp0_valid_exec", 32'(resp0_valid), 32'd0);
      tick();
      resp1_ready = 1'b1;
      settle();
      chk("rm_resp0_valid_resp", 32'(resp0_valid), 32'd0);
      chk("rm_resp1_valid", 32'(resp1_valid), 32'd1);
      chk("rm_resp1_data", resp1_data, 32'd3);
      tick();
      resp1_ready = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
